dmem_wbuf: RTL and testbench

DMEM_WBUF -- requirements
Module: dmem_wbuf

---
 rtl/dmem_wbuf.sv | 150 +++++++++++++++
 tb/tb_dmem_wbuf.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wbuf.sv
// Data-memory store buffer: in-order write FIFO drained to a handshaked backing memory, plus load handling.
// Define DMEM_WBUF_FWD_EN to forward buffered store data to matching loads instead of draining first.
module dmem_wbuf #(
   parameter int N     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N-1:0]             DM_addr,
   input  logic [N-1:0]             DM_writeData,
   input  logic                     DM_writeEnable,
   input  logic                     DM_readEnable,
   output logic [N-1:0]             DM_readData,
   output logic                     stall,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [N-1:0]             mem_addr,
   output logic [N-1:0]             mem_wdata,
   input  logic                     mem_ack,
   input  logic [N-1:0]             mem_rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, READ, RDONE} state_t;

   state_t         state;
   logic [N-1:0]   addr_q [DEPTH];
   logic [N-1:0]   data_q [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [N-1:0]   rdata_q;
   logic           match;
   logic           full;
   logic           load_req;
   logic           load_miss;
   logic           load_block;
   logic           push;
   logic           pop;
`ifdef DMEM_WBUF_FWD_EN
   logic [N-1:0]   fwd_data;
`endif

   // Scan valid entries oldest to youngest so the last hit is the youngest store.
   always_comb begin
      match = 1'b0;
`ifdef DMEM_WBUF_FWD_EN
      fwd_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count) && (addr_q[head + PW'(i)] == DM_addr)) begin
            match = 1'b1;
`ifdef DMEM_WBUF_FWD_EN
            fwd_data = data_q[head + PW'(i)];
`endif
         end
      end
   end

   assign full      = (count == CW'(DEPTH));
   assign load_req  = DM_readEnable & ~DM_writeEnable;
   assign load_miss = load_req & ~match;
`ifdef DMEM_WBUF_FWD_EN
   assign load_block = load_miss;
`else
   assign load_block = load_req;
`endif
   assign stall = reset & ((DM_writeEnable & full) | (load_block & (state != RDONE)));
   assign push  = DM_writeEnable & ~full;
   assign pop   = (state == DRAIN) & mem_ack;

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      DM_readData = '0;
      if (state == RDONE) DM_readData = rdata_q;
`ifdef DMEM_WBUF_FWD_EN
      else if (load_req && match) DM_readData = fwd_data;
`endif
   end

   // NOTE: the entry storage has no reset; head/tail/count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= DM_addr;
         data_q[tail] <= DM_writeData;
      end
   end

   // NOTE: registered state always uses non-blocking assignments.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Request outputs are loaded on entry to DRAIN/READ and held untouched until mem_ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_miss) begin
                  state     <= READ;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= DM_addr;
                  mem_wdata <= '0;
               end else if (count != '0) begin
                  state     <= DRAIN;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q[head];
                  mem_wdata <= data_q[head];
               end
            end
            DRAIN: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            READ: begin
               if (mem_ack) begin
                  state   <= RDONE;
                  mem_req <= 1'b0;
                  rdata_q <= mem_rdata;
               end
            end
            RDONE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: directed scenarios plus random load/store traffic,
// scored against an architectural memory model (last store in program order wins).
module tb_dmem_wbuf;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic [63:0] DM_addr;
   logic [63:0] DM_writeData;
   logic        DM_writeEnable;
   logic        DM_readEnable;
   logic [63:0] DM_readData;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   logic [63:0] arch [logic [63:0]];
   logic [63:0] bmem [logic [63:0]];
   wr_t         exp_wr_q [$];
   logic [63:0] exp_ld_q [$];

   bit resp_en = 0;
   bit ack_go  = 0;
   bit raw_ack = 0;
   int lat_fix = 0;

   dmem_wbuf #(.N(64), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .DM_addr(DM_addr), .DM_writeData(DM_writeData),
      .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
      .DM_readData(DM_readData), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] init_val(input logic [63:0] a);
      if (a == 64'h40) return 64'hBEEF;
      return a ^ 64'h5A5A_0000_0000_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // Backing memory: auto-acks after a random or fixed latency, or once on request (ack_go).
   initial begin : responder
      logic [63:0] ra, rd;
      logic        rw;
      int          rn;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = '0;
         if (raw_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 64'hDEAD;
         end else if (reset && mem_req && (resp_en || ack_go)) begin
            ra = mem_addr;
            rw = mem_we;
            rd = mem_wdata;
            rn = ack_go ? 1 : (lat_fix != 0 ? lat_fix : int'($urandom_range(1, 3)));
            repeat (rn - 1) @(negedge clk);
            if (rn > 1) begin
               check("mem_req_stable", {63'b0, mem_req}, 64'd1);
               check("mem_we_stable", {63'b0, mem_we}, {63'b0, rw});
               check("mem_addr_stable", mem_addr, ra);
               check("mem_wdata_stable", mem_wdata, rd);
            end
            if (rw) begin
               if (exp_wr_q.size() == 0) fail("unexpected_write");
               else begin
                  wr_t e;
                  e = exp_wr_q.pop_front();
                  check("write_addr", ra, e.addr);
                  check("write_data", rd, e.data);
               end
               bmem[ra] = rd;
            end else begin
               mem_rdata = bmem.exists(ra) ? bmem[ra] : init_val(ra);
            end
            mem_ack = 1'b1;
         end
      end
   end

   // Load monitor: every completed load is scored; otherwise DM_readData must be zero.
   initial begin : load_monitor
      forever begin
         @(negedge clk);
         if (reset && DM_readEnable && !DM_writeEnable && !stall) begin
            if (exp_ld_q.size() == 0) fail("unexpected_load_completion");
            else check("load_data", DM_readData, exp_ld_q.pop_front());
         end else begin
            check("readdata_idle_zero", DM_readData, 64'd0);
         end
      end
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Drive one request at posedge+1 and hold it until accepted (stall low at the edge).
   task automatic do_op(input logic we, input logic re, input logic [63:0] a, input logic [63:0] d);
      int  n;
      wr_t e;
      DM_writeEnable = we;
      DM_readEnable  = re;
      DM_addr        = a;
      DM_writeData   = d;
      if (we) begin
         arch[a] = d;
         e.addr  = a;
         e.data  = d;
         exp_wr_q.push_back(e);
      end else if (re) begin
         exp_ld_q.push_back(arch.exists(a) ? arch[a] : init_val(a));
      end
      n = 0;
      @(negedge clk);
      while (stall && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (stall) fail("op_accept_timeout");
      @(posedge clk);
      #1;
      DM_writeEnable = 1'b0;
      DM_readEnable  = 1'b0;
   endtask

   task automatic do_store(input logic [63:0] a, input logic [63:0] d);
      do_op(1'b1, 1'b0, a, d);
   endtask

   task automatic do_load(input logic [63:0] a);
      do_op(1'b0, 1'b1, a, 64'd0);
   endtask

   task automatic manual_ack();
      @(posedge clk);
      #1 ack_go = 1'b1;
      @(negedge clk);
      #1 ack_go = 1'b0;
      @(negedge clk);
      check("req_drop_after_ack", {63'b0, mem_req}, 64'd0);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (count != 3'd0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_to_empty", {61'b0, count}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {63'b0, stall}, 64'd0);
      check({tag, "_mem_req"}, {63'b0, mem_req}, 64'd0);
      check({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
      check({tag, "_mem_addr"}, mem_addr, 64'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
      check({tag, "_readdata"}, DM_readData, 64'd0);
      check({tag, "_count"}, {61'b0, count}, 64'd0);
   endtask

   initial begin : main
      logic [63:0] a, d;
      int r;
      reset          = 1'b0;
      DM_writeEnable = 1'b0;
      DM_readEnable  = 1'b1;
      DM_addr        = 64'h40;
      DM_writeData   = '0;
      repeat (2) @(posedge clk);
      #2 check_all_zero("reset");
      DM_readEnable = 1'b0;
      align();
      reset = 1'b1;

      // Single store drained with a fixed two-cycle ack.
      lat_fix = 2;
      resp_en = 1'b1;
      do_store(64'h10, 64'hAA);
      @(negedge clk);
      check("store_count_one", {61'b0, count}, 64'd1);
      @(negedge clk);
      check("drain_req", {63'b0, mem_req}, 64'd1);
      check("drain_we", {63'b0, mem_we}, 64'd1);
      check("drain_addr", mem_addr, 64'h10);
      check("drain_wdata", mem_wdata, 64'hAA);
      wait_empty();
      align();

      // Fill to DEPTH with the memory silent, then a fifth store must wait for one pop.
      resp_en = 1'b0;
      lat_fix = 0;
      for (int i = 0; i < 4; i++) do_store(64'h200 + 64'(8 * i), 64'h100 + 64'(i));
      check("fifo_full_count", {61'b0, count}, 64'd4);
      fork
         do_store(64'h300, 64'h55);
         begin
            @(negedge clk);
            check("full_stall", {63'b0, stall}, 64'd1);
            @(negedge clk);
            check("full_stall_held", {63'b0, stall}, 64'd1);
            @(posedge clk);
            #1 ack_go = 1'b1;
            @(negedge clk);
            #1 ack_go = 1'b0;
            check("stall_during_ack", {63'b0, stall}, 64'd1);
            @(negedge clk);
            check("stall_after_pop", {63'b0, stall}, 64'd0);
            check("count_after_pop", {61'b0, count}, 64'd3);
            resp_en = 1'b1;
            @(negedge clk);
            check("count_after_refill", {61'b0, count}, 64'd4);
         end
      join
      wait_empty();
      align();

      // Two stores to one address, then a load of it.
      lat_fix = 3;
      do_store(64'h20, 64'h1);
      do_store(64'h20, 64'h2);
      fork
         do_load(64'h20);
         begin
            @(negedge clk);
`ifdef DMEM_WBUF_FWD_EN
            check("fwd_no_stall", {63'b0, stall}, 64'd0);
            check("fwd_youngest", DM_readData, 64'h2);
`else
            check("match_stall", {63'b0, stall}, 64'd1);
`endif
         end
      join
      wait_empty();
      align();

      // Load miss arriving during a drain: write completes first, then the read.
      resp_en = 1'b0;
      lat_fix = 0;
      do_store(64'h10, 64'h77);
      align();
      fork
         do_load(64'h40);
         begin
            @(negedge clk);
            check("miss_in_drain_stall", {63'b0, stall}, 64'd1);
            check("drain_before_read", {63'b0, mem_we}, 64'd1);
            manual_ack();
            check("stall_between", {63'b0, stall}, 64'd1);
            @(negedge clk);
            check("read_req", {63'b0, mem_req}, 64'd1);
            check("read_we", {63'b0, mem_we}, 64'd0);
            check("read_addr", mem_addr, 64'h40);
            manual_ack();
            check("rdone_stall", {63'b0, stall}, 64'd0);
         end
      join
      @(negedge clk);
      check("rdone_one_cycle", DM_readData, 64'd0);
      align();

      // Asynchronous reset in the middle of a READ with two stores still buffered.
      do_store(64'h100, 64'h1);
      do_store(64'h108, 64'h2);
      do_store(64'h110, 64'h3);
      DM_readEnable = 1'b1;
      DM_addr       = 64'h300;
      manual_ack();
      @(negedge clk);
      check("pre_reset_read_req", {63'b0, mem_req}, 64'd1);
      check("pre_reset_read_we", {63'b0, mem_we}, 64'd0);
      check("pre_reset_count", {61'b0, count}, 64'd2);
      @(posedge clk);
      #3 reset = 1'b0;
      DM_readEnable = 1'b0;
      #1 check_all_zero("async_reset");
      align();
      reset = 1'b1;
      exp_wr_q.delete();
      arch.delete();
      foreach (bmem[k]) arch[k] = bmem[k];
      raw_ack = 1'b1;
      @(negedge clk);
      #1 raw_ack = 1'b0;
      @(negedge clk);
      check_all_zero("late_ack");
      align();

      // Random traffic against the architectural model.
      resp_en = 1'b1;
      lat_fix = 0;
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 9));
         a = 64'h1000 + 64'(8 * $urandom_range(0, 5));
         d = {$urandom, $urandom};
         if (r < 4)       do_store(a, d);
         else if (r < 7)  do_load(a);
         else if (r == 7) do_op(1'b1, 1'b1, a, d);
         else             align();
      end
      wait_empty();
      repeat (3) @(negedge clk);
      check("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
      check("loads_outstanding", 64'(exp_ld_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
